song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1562500, clock cycles per duration tick (min 2).
REQ-002 SHALL have port iClk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port iReset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port iStart  in  1  start pulse; song index sampled from iSongSel.
REQ-005 SHALL have port iStop  in  1  abort current playback.
REQ-006 SHALL have port iSongSel  in  4  song index; 0 = free play.
REQ-007 SHALL have port iKeyFreq  in  8  live keyboard freq type, used in free play.
REQ-008 SHALL have port oRomAddr  out  12  note ROM address, registered.
REQ-009 SHALL have port iRomData  in  16  ROM word for the previous cycle's oRomAddr; [15:8] freq type, [7:0] duration in ticks.
REQ-010 SHALL have port oFreqType  out  8  freq type to the display and tone paths; 0 = silence.
REQ-011 SHALL have port oProgress  out  8  percent complete, 0..100.
REQ-012 SHALL have port oSongSelected  out  4  latched song index.
REQ-013 SHALL have port oBusy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port oDone  out  1  one-cycle pulse on normal song completion.

Function
REQ-015 SHALL use states IDLE, FREE, HDR_REQ, HDR_WAIT, NOTE_REQ, NOTE_WAIT, PLAY, PROG, DONE.
REQ-016 SHALL, in IDLE with iStart=1 and iStop=0: latch iSongSel into oSongSelected, clear oProgress; go to FREE if iSongSel=0, else HDR_REQ with oRomAddr={iSongSel,8'h00}.
REQ-017 SHALL, in FREE, register iKeyFreq into oFreqType every cycle (1-cycle latency) and hold oProgress=0.
REQ-018 SHALL move HDR_REQ->HDR_WAIT in one cycle; in HDR_WAIT it latches N=iRomData[7:0] (note count) and clears the note index i and the 9-bit remainder acc.
REQ-019 SHALL, in HDR_WAIT with N=0, go to DONE; otherwise set oRomAddr=base+1 and go to NOTE_REQ.
REQ-020 SHALL move NOTE_REQ->NOTE_WAIT in one cycle; in NOTE_WAIT it latches freq=[15:8] and D=[7:0].
REQ-021 SHALL, in NOTE_WAIT with D=0 (end marker), go to DONE; else drive oFreqType=freq and go to PLAY with the cycle and tick counters cleared.
REQ-022 SHALL remain in PLAY for exactly D*TICK_DIV cycles, oFreqType constant, then increment i, add 100 to acc, and go to PROG.
REQ-023 SHALL, in PROG, perform one step per cycle: if acc>=N then acc-=N and oProgress+=1; else exit PROG.
REQ-024 SHALL, on exiting PROG, go to DONE if i=N; else set oRomAddr=base+1+i and go to NOTE_REQ.
REQ-025 SHALL give oProgress=floor(i*100/N) after each note; no divider is used.
REQ-026 SHALL, in DONE, set oFreqType=0 and oProgress=100, pulse oDone for one cycle, then go to IDLE; oProgress and oSongSelected hold in IDLE.
REQ-027 SHALL, when iStop=1 in any non-IDLE state, go to IDLE next cycle with oFreqType=0, oProgress=0, and no oDone pulse.
REQ-028 SHALL let iStop win when iStop and iStart are asserted together; iStart outside IDLE is ignored.
REQ-029 SHALL treat freq=0 notes as rests that still consume D ticks and advance progress.
REQ-030 SHALL ignore changes of iSongSel while oBusy=1.

Reset
REQ-031 SHALL, with iReset=1 at a clock edge, force state IDLE, oRomAddr=0, oFreqType=0, oProgress=0, oSongSelected=0, oBusy=0, oDone=0, and clear all counters, i and acc.
REQ-032 SHALL let reset take priority over iStart and iStop, including mid-note and mid-PROG.

Verification (TICK_DIV=4)
REQ-033 SHALL cover: reset asserted during PLAY -> next cycle all outputs 0, oBusy=0.
REQ-034 SHALL cover: song 1, header N=4, notes (8,2)(10,1)(0,1)(12,3) -> oFreqType=8 for 8 cycles, 10 for 4, 0 for 4, 12 for 12; oProgress 25,50,75,100; one oDone pulse; addresses 0x100..0x104.
REQ-035 SHALL cover: N=3, all D=1 -> oProgress steps 33, 66, 100.
REQ-036 SHALL cover: iStop two cycles into a note -> next cycle oFreqType=0, oProgress=0, oBusy=0, no oDone.
REQ-037 SHALL cover: iSongSel=0 with iStart, iKeyFreq=15 -> oFreqType=15 one cycle later, oProgress=0, oBusy=1, no ROM fetch.
REQ-038 SHALL cover: N=5 with the second note D=0 -> DONE after the first note, oProgress=100, oDone pulse.

Source files
------------

// File: rtl/song_sequencer_if.sv
// Control, note-ROM and status signals of the song sequencer.
// The slave modport is the sequencer side; the master modport is the side
// that drives start/stop, selects songs, answers ROM reads and watches status.
interface song_sequencer_if;
  logic        iStart;
  logic        iStop;
  logic [3:0]  iSongSel;
  logic [7:0]  iKeyFreq;
  logic [11:0] oRomAddr;
  logic [15:0] iRomData;
  logic [7:0]  oFreqType;
  logic [7:0]  oProgress;
  logic [3:0]  oSongSelected;
  logic        oBusy;
  logic        oDone;

  modport slave (
    input  iStart, iStop, iSongSel, iKeyFreq, iRomData,
    output oRomAddr, oFreqType, oProgress, oSongSelected, oBusy, oDone
  );

  modport master (
    output iStart, iStop, iSongSel, iKeyFreq, iRomData,
    input  oRomAddr, oFreqType, oProgress, oSongSelected, oBusy, oDone
  );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks a note table in ROM (header word holds the note
// count, each note word holds freq type and duration in ticks), plays each
// note for its duration, and tracks percent-complete without a divider by
// repeated subtraction of the note count from a running remainder.
// Song 0 is free play: the live keyboard frequency is passed straight through.
module song_sequencer #(
  parameter int TICK_DIV = 1562500
) (
  input  logic            iClk,
  input  logic            iReset,
  song_sequencer_if.slave bus
);
  localparam int TickW = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, FREE, HDR_REQ, HDR_WAIT, NOTE_REQ, NOTE_WAIT, PLAY, PROG, DONE
  } state_t;

  state_t           state;
  logic [7:0]       noteCount;  // N from the song header
  logic [7:0]       noteIdx;    // notes fully played so far
  logic [7:0]       noteDur;    // duration of the current note in ticks
  logic [7:0]       durCnt;     // ticks elapsed in the current note
  logic [TickW-1:0] tickCnt;    // clock cycles elapsed in the current tick
  logic [8:0]       acc;        // remainder of noteIdx*100 not yet turned into percent
  logic [11:0]      songBase;

  assign songBase  = {bus.oSongSelected, 8'h00};
  assign bus.oBusy = (state != IDLE);

  // Playback FSM with all outputs registered; stop aborts from any active state.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state             <= IDLE;
      bus.oRomAddr      <= '0;
      bus.oFreqType     <= '0;
      bus.oProgress     <= '0;
      bus.oSongSelected <= '0;
      bus.oDone         <= 1'b0;
      noteCount         <= '0;
      noteIdx           <= '0;
      noteDur           <= '0;
      durCnt            <= '0;
      tickCnt           <= '0;
      acc               <= '0;
    end else begin
      bus.oDone <= 1'b0;
      if (bus.iStop && state != IDLE) begin
        state         <= IDLE;
        bus.oFreqType <= '0;
        bus.oProgress <= '0;
        tickCnt       <= '0;
        durCnt        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.iStart && !bus.iStop) begin
              bus.oSongSelected <= bus.iSongSel;
              bus.oProgress     <= '0;
              if (bus.iSongSel == 4'd0) begin
                bus.oFreqType <= bus.iKeyFreq;
                state         <= FREE;
              end else begin
                bus.oRomAddr <= {bus.iSongSel, 8'h00};
                state        <= HDR_REQ;
              end
            end
          end
          FREE: begin
            bus.oFreqType <= bus.iKeyFreq;
            bus.oProgress <= '0;
          end
          HDR_REQ: state <= HDR_WAIT;
          HDR_WAIT: begin
            noteCount <= bus.iRomData[7:0];
            noteIdx   <= '0;
            acc       <= '0;
            if (bus.iRomData[7:0] == 8'd0) begin
              state <= DONE;
            end else begin
              bus.oRomAddr <= songBase + 12'd1;
              state        <= NOTE_REQ;
            end
          end
          NOTE_REQ: state <= NOTE_WAIT;
          NOTE_WAIT: begin
            noteDur <= bus.iRomData[7:0];
            if (bus.iRomData[7:0] == 8'd0) begin
              state <= DONE;
            end else begin
              bus.oFreqType <= bus.iRomData[15:8];
              tickCnt       <= '0;
              durCnt        <= '0;
              state         <= PLAY;
            end
          end
          PLAY: begin
            if (tickCnt == TickLast) begin
              tickCnt <= '0;
              if (durCnt == noteDur - 8'd1) begin
                noteIdx <= noteIdx + 8'd1;
                acc     <= acc + 9'd100;
                state   <= PROG;
              end else begin
                durCnt <= durCnt + 8'd1;
              end
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
          PROG: begin
            if (acc >= {1'b0, noteCount}) begin
              acc           <= acc - {1'b0, noteCount};
              bus.oProgress <= bus.oProgress + 8'd1;
            end else if (noteIdx == noteCount) begin
              state <= DONE;
            end else begin
              bus.oRomAddr <= songBase + 12'd1 + {4'd0, noteIdx};
              state        <= NOTE_REQ;
            end
          end
          DONE: begin
            bus.oFreqType <= '0;
            bus.oProgress <= 8'd100;
            bus.oDone     <= 1'b1;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4 and a synchronous note ROM.
module tb_song_sequencer;
  localparam int TD = 4;

  logic iClk;
  logic iReset;
  song_sequencer_if bus ();

  song_sequencer #(.TICK_DIV(TD)) dut (
    .iClk  (iClk),
    .iReset(iReset),
    .bus   (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic [15:0] rom [0:4095];

  // Synchronous ROM: data answers the previous cycle's address.
  always @(posedge iClk) bus.iRomData <= rom[bus.oRomAddr];

  int checks = 0;
  int errors = 0;

  // Trace of one song: runs of constant oFreqType, progress at each run start,
  // and the sequence of distinct ROM addresses.
  logic [7:0]  runVal  [0:15];
  int          runLen  [0:15];
  logic [7:0]  runProg [0:15];
  logic [11:0] addrs   [0:15];
  int nRuns, nAddr, doneCnt;
  bit timedOut;

  task automatic record_song(input logic [3:0] sel, input int budget);
    nRuns = 0; nAddr = 0; doneCnt = 0; timedOut = 1'b0;
    @(negedge iClk);
    bus.iSongSel = sel;
    bus.iStart   = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge iClk);
      if (nRuns == 0 || runVal[nRuns-1] !== bus.oFreqType) begin
        if (nRuns < 16) begin
          runVal[nRuns]  = bus.oFreqType;
          runLen[nRuns]  = 1;
          runProg[nRuns] = bus.oProgress;
          nRuns++;
        end
      end else begin
        runLen[nRuns-1]++;
      end
      if ((nAddr == 0 || addrs[nAddr-1] !== bus.oRomAddr) && nAddr < 16) begin
        addrs[nAddr] = bus.oRomAddr;
        nAddr++;
      end
      if (bus.oDone === 1'b1) begin
        doneCnt++;
        break;
      end
    end
    if (doneCnt == 0) timedOut = 1'b1;
  endtask

  task automatic test_reset;
    iReset = 1'b1;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    checks++;
    if (bus.oFreqType !== 8'd0 || bus.oProgress !== 8'd0 || bus.oSongSelected !== 4'd0 ||
        bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oRomAddr !== 12'd0) begin
      errors++;
      $display("FAIL reset: got freq=%0d prog=%0d sel=%0d busy=%b done=%b addr=%h, expected all zero",
               bus.oFreqType, bus.oProgress, bus.oSongSelected, bus.oBusy, bus.oDone, bus.oRomAddr);
    end
    iReset = 1'b0;
  endtask

  task automatic test_song_basic;
    logic [7:0] expV [6] = '{8'd0, 8'd8, 8'd10, 8'd0, 8'd12, 8'd0};
    int         expL [6] = '{4, 36, 32, 32, 39, 1};
    logic [7:0] expP [6] = '{8'd0, 8'd0, 8'd25, 8'd50, 8'd75, 8'd100};
    int extraDone = 0;
    record_song(4'd1, 400);
    checks++;
    if (timedOut || nRuns != 6) begin
      errors++;
      $display("FAIL song1_shape: got runs=%0d timeout=%b, expected runs=6 timeout=0", nRuns, timedOut);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (runVal[k] !== expV[k] || runLen[k] != expL[k] || runProg[k] !== expP[k]) begin
        errors++;
        $display("FAIL song1_run%0d: got freq=%0d len=%0d prog=%0d, expected freq=%0d len=%0d prog=%0d",
                 k, runVal[k], runLen[k], runProg[k], expV[k], expL[k], expP[k]);
      end
    end
    checks++;
    if (nAddr != 5) begin
      errors++;
      $display("FAIL song1_addr_count: got %0d, expected 5", nAddr);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (addrs[k] !== 12'h100 + 12'(k)) begin
        errors++;
        $display("FAIL song1_addr%0d: got %h, expected %h", k, addrs[k], 12'h100 + 12'(k));
      end
    end
    checks++;
    if (bus.oProgress !== 8'd100 || bus.oBusy !== 1'b0 || bus.oSongSelected !== 4'd1) begin
      errors++;
      $display("FAIL song1_end: got prog=%0d busy=%b sel=%0d, expected prog=100 busy=0 sel=1",
               bus.oProgress, bus.oBusy, bus.oSongSelected);
    end
    repeat (4) begin
      @(negedge iClk);
      if (bus.oDone === 1'b1) extraDone++;
    end
    checks++;
    if (extraDone != 0 || bus.oProgress !== 8'd100 || bus.oSongSelected !== 4'd1) begin
      errors++;
      $display("FAIL song1_idle_hold: got extra_done=%0d prog=%0d sel=%0d, expected 0, 100, 1",
               extraDone, bus.oProgress, bus.oSongSelected);
    end
  endtask

  task automatic test_thirds;
    logic [7:0] expV [5] = '{8'd0, 8'd5, 8'd6, 8'd7, 8'd0};
    int         expL [5] = '{4, 40, 40, 40, 1};
    logic [7:0] expP [5] = '{8'd0, 8'd0, 8'd33, 8'd66, 8'd100};
    record_song(4'd2, 400);
    checks++;
    if (timedOut || nRuns != 5) begin
      errors++;
      $display("FAIL thirds_shape: got runs=%0d timeout=%b, expected runs=5 timeout=0", nRuns, timedOut);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (runVal[k] !== expV[k] || runLen[k] != expL[k] || runProg[k] !== expP[k]) begin
        errors++;
        $display("FAIL thirds_run%0d: got freq=%0d len=%0d prog=%0d, expected freq=%0d len=%0d prog=%0d",
                 k, runVal[k], runLen[k], runProg[k], expV[k], expL[k], expP[k]);
      end
    end
  endtask

  // Started on the cycle right after the previous song's done pulse.
  task automatic test_back_to_back_end_marker;
    logic [7:0] expV [3] = '{8'd0, 8'd9, 8'd0};
    int         expL [3] = '{4, 28, 1};
    logic [7:0] expP [3] = '{8'd0, 8'd0, 8'd100};
    record_song(4'd3, 200);
    checks++;
    if (timedOut || nRuns != 3 || doneCnt != 1) begin
      errors++;
      $display("FAIL marker_shape: got runs=%0d done=%0d timeout=%b, expected runs=3 done=1 timeout=0",
               nRuns, doneCnt, timedOut);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (runVal[k] !== expV[k] || runLen[k] != expL[k] || runProg[k] !== expP[k]) begin
        errors++;
        $display("FAIL marker_run%0d: got freq=%0d len=%0d prog=%0d, expected freq=%0d len=%0d prog=%0d",
                 k, runVal[k], runLen[k], runProg[k], expV[k], expL[k], expP[k]);
      end
    end
  endtask

  task automatic test_empty_song;
    record_song(4'd4, 50);
    checks++;
    if (timedOut || nRuns != 1 || runLen[0] != 4 || bus.oProgress !== 8'd100 || bus.oFreqType !== 8'd0) begin
      errors++;
      $display("FAIL empty_song: got runs=%0d len=%0d prog=%0d freq=%0d timeout=%b, expected 1, 4, 100, 0, 0",
               nRuns, runLen[0], bus.oProgress, bus.oFreqType, timedOut);
    end
  endtask

  task automatic test_stop;
    bit seen = 1'b0;
    int doneSeen = 0;
    @(negedge iClk);
    bus.iSongSel = 4'd1;
    bus.iStart   = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      if (bus.oFreqType === 8'd10) seen = 1'b1;
      else @(negedge iClk);
    end
    checks++;
    if (!seen || bus.oProgress !== 8'd25) begin
      errors++;
      $display("FAIL stop_reach_note2: got seen=%b prog=%0d, expected seen=1 prog=25", seen, bus.oProgress);
    end
    @(negedge iClk);
    bus.iStop = 1'b1;
    @(negedge iClk);
    bus.iStop = 1'b0;
    checks++;
    if (bus.oFreqType !== 8'd0 || bus.oProgress !== 8'd0 || bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
      errors++;
      $display("FAIL stop: got freq=%0d prog=%0d busy=%b done=%b, expected 0 0 0 0",
               bus.oFreqType, bus.oProgress, bus.oBusy, bus.oDone);
    end
    repeat (5) begin
      @(negedge iClk);
      if (bus.oDone === 1'b1 || bus.oBusy === 1'b1) doneSeen++;
    end
    checks++;
    if (doneSeen != 0 || bus.oSongSelected !== 4'd1) begin
      errors++;
      $display("FAIL stop_quiet: got done_or_busy=%0d sel=%0d, expected 0 and 1", doneSeen, bus.oSongSelected);
    end
  endtask

  task automatic test_stop_start_idle;
    bus.iSongSel = 4'd2;
    bus.iStart   = 1'b1;
    bus.iStop    = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
    bus.iStop  = 1'b0;
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oSongSelected !== 4'd1) begin
      errors++;
      $display("FAIL stop_wins: got busy=%b sel=%0d, expected busy=0 sel=1", bus.oBusy, bus.oSongSelected);
    end
  endtask

  task automatic test_free_play;
    bus.iKeyFreq = 8'd15;
    bus.iSongSel = 4'd0;
    bus.iStart   = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
    checks++;
    if (bus.oFreqType !== 8'd15 || bus.oProgress !== 8'd0 || bus.oBusy !== 1'b1 || bus.oSongSelected !== 4'd0) begin
      errors++;
      $display("FAIL free_start: got freq=%0d prog=%0d busy=%b sel=%0d, expected 15 0 1 0",
               bus.oFreqType, bus.oProgress, bus.oBusy, bus.oSongSelected);
    end
    bus.iKeyFreq = 8'd3;
    bus.iSongSel = 4'd7;
    bus.iStart   = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
    checks++;
    if (bus.oFreqType !== 8'd3 || bus.oSongSelected !== 4'd0 || bus.oRomAddr !== 12'h102 || bus.oBusy !== 1'b1) begin
      errors++;
      $display("FAIL free_follow: got freq=%0d sel=%0d addr=%h busy=%b, expected 3 0 102 1",
               bus.oFreqType, bus.oSongSelected, bus.oRomAddr, bus.oBusy);
    end
    bus.iStop = 1'b1;
    @(negedge iClk);
    bus.iStop = 1'b0;
    checks++;
    if (bus.oFreqType !== 8'd0 || bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL free_stop: got freq=%0d busy=%b, expected 0 0", bus.oFreqType, bus.oBusy);
    end
  endtask

  task automatic test_reset_mid_play;
    bit seen = 1'b0;
    @(negedge iClk);
    bus.iSongSel = 4'd2;
    bus.iStart   = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.oFreqType === 8'd5) seen = 1'b1;
      else @(negedge iClk);
    end
    @(negedge iClk);
    iReset     = 1'b1;
    bus.iStart = 1'b1;
    bus.iStop  = 1'b1;
    @(negedge iClk);
    iReset     = 1'b0;
    bus.iStart = 1'b0;
    bus.iStop  = 1'b0;
    checks++;
    if (!seen || bus.oFreqType !== 8'd0 || bus.oProgress !== 8'd0 || bus.oSongSelected !== 4'd0 ||
        bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oRomAddr !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_play: got seen=%b freq=%0d prog=%0d sel=%0d busy=%b done=%b addr=%h, expected seen=1 rest zero",
               seen, bus.oFreqType, bus.oProgress, bus.oSongSelected, bus.oBusy, bus.oDone, bus.oRomAddr);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 16'h0000;
    rom[12'h100] = 16'h0004;
    rom[12'h101] = 16'h0802;
    rom[12'h102] = 16'h0A01;
    rom[12'h103] = 16'h0001;
    rom[12'h104] = 16'h0C03;
    rom[12'h200] = 16'h0003;
    rom[12'h201] = 16'h0501;
    rom[12'h202] = 16'h0601;
    rom[12'h203] = 16'h0701;
    rom[12'h300] = 16'h0005;
    rom[12'h301] = 16'h0901;
    rom[12'h302] = 16'h0B00;
    rom[12'h303] = 16'h0D01;
    rom[12'h400] = 16'h0000;

    iReset       = 1'b1;
    bus.iStart   = 1'b0;
    bus.iStop    = 1'b0;
    bus.iSongSel = 4'd0;
    bus.iKeyFreq = 8'd0;

    test_reset;
    test_song_basic;
    test_thirds;
    test_back_to_back_end_marker;
    test_empty_song;
    test_stop;
    test_stop_start_idle;
    test_free_play;
    test_reset_mid_play;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
